dmem_arbiter: RTL and testbench

- Sequences and shares the single-port data memory between the instruction-fetch requester (IF) and the load/store requester (MEM).
- Arbitrates, registers the winning request onto a variable-latency RAM port and holds it until completion, then returns a one-cycle response to the winner.
- Sits between the IF/MEM pipeline stages and the data memory, and drives their stall signals.

---
 rtl/dmem_arbiter_if.sv | 53 +++++
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle tying the IF and MEM requesters and the single-port RAM to the data-memory arbiter.
// The arbiter uses the slave view; the requesters and RAM together form the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;
    logic              if_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_err;
    logic              mem_stall;

    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [BE_W-1:0]   ram_be;
    logic              ram_ready;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  ram_ready, ram_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err, if_stall,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err, mem_stall,
        output ram_req, ram_we, ram_addr, ram_wdata, ram_be
    );

    modport master (
        output if_req, if_addr,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output ram_ready, ram_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err, if_stall,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err, mem_stall,
        input  ram_req, ram_we, ram_addr, ram_wdata, ram_be
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between instruction fetch and load/store, with
// MEM priority, an IF anti-starvation override and early rejection of misaligned accesses.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           resetn,
    dmem_arbiter_if.slave bus
);
    localparam int         BE_W  = DATA_W / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic { IDLE, ACCESS } stateT;
    typedef enum logic { OWNER_IF, OWNER_MEM } ownerT;

    stateT      state;
    ownerT      owner;
    logic [3:0] starveCnt;

    logic       forceIf;
    logic       memWin;
    logic       ifWin;
    logic       memBad;
    logic       ifBad;
    logic [1:0] memLane;

    // Grants are combinational and suppressed while reset is held so every output reads 0.
    always_comb begin
        forceIf = bus.if_req && (starveCnt == LIMIT);
        memWin  = (state == IDLE) && !resetn && bus.mem_req && !forceIf;
        ifWin   = (state == IDLE) && !resetn && bus.if_req && !memWin;
    end

    always_comb begin
        memLane = bus.mem_addr[1:0];
        memBad  = 1'b1;
        if (bus.mem_be == BE_W'(4'b1111) && memLane == 2'd0) memBad = 1'b0;
        if (bus.mem_be == BE_W'(4'b0011) && memLane == 2'd0) memBad = 1'b0;
        if (bus.mem_be == BE_W'(4'b1100) && memLane == 2'd2) memBad = 1'b0;
        if (bus.mem_be == (BE_W'(1) << memLane))              memBad = 1'b0;
        ifBad = (bus.if_addr[1:0] != 2'b00);
    end

    assign bus.if_gnt    = ifWin;
    assign bus.mem_gnt   = memWin;
    assign bus.if_stall  = bus.if_req  && !ifWin  && !resetn;
    assign bus.mem_stall = bus.mem_req && !memWin && !resetn;

    // Rejected grants answer from IDLE the next cycle; accepted ones park on the RAM port until ready.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state          <= IDLE;
            owner          <= OWNER_IF;
            starveCnt      <= '0;
            bus.ram_req    <= 1'b0;
            bus.ram_we     <= 1'b0;
            bus.ram_addr   <= '0;
            bus.ram_wdata  <= '0;
            bus.ram_be     <= '0;
            bus.if_rvalid  <= 1'b0;
            bus.if_rdata   <= '0;
            bus.if_err     <= 1'b0;
            bus.mem_rvalid <= 1'b0;
            bus.mem_rdata  <= '0;
            bus.mem_err    <= 1'b0;
        end else begin
            bus.if_rvalid  <= 1'b0;
            bus.mem_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (memWin) begin
                        if (!bus.if_req)
                            starveCnt <= '0;
                        else if (starveCnt < LIMIT)
                            starveCnt <= starveCnt + 4'd1;
                        if (memBad) begin
                            bus.mem_rvalid <= 1'b1;
                            bus.mem_err    <= 1'b1;
                            bus.mem_rdata  <= '0;
                        end else begin
                            owner         <= OWNER_MEM;
                            bus.ram_req   <= 1'b1;
                            bus.ram_we    <= bus.mem_we;
                            bus.ram_addr  <= bus.mem_addr;
                            bus.ram_wdata <= bus.mem_wdata;
                            bus.ram_be    <= bus.mem_be;
                            state         <= ACCESS;
                        end
                    end else if (ifWin) begin
                        starveCnt <= '0;
                        if (ifBad) begin
                            bus.if_rvalid <= 1'b1;
                            bus.if_err    <= 1'b1;
                            bus.if_rdata  <= '0;
                        end else begin
                            owner         <= OWNER_IF;
                            bus.ram_req   <= 1'b1;
                            bus.ram_we    <= 1'b0;
                            bus.ram_addr  <= bus.if_addr;
                            bus.ram_wdata <= '0;
                            bus.ram_be    <= '1;
                            state         <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.ram_ready) begin
                        bus.ram_req <= 1'b0;
                        state       <= IDLE;
                        if (owner == OWNER_MEM) begin
                            bus.mem_rvalid <= 1'b1;
                            bus.mem_err    <= 1'b0;
                            bus.mem_rdata  <= bus.ram_rdata;
                        end else begin
                            bus.if_rvalid <= 1'b1;
                            bus.if_err    <= 1'b0;
                            bus.if_rdata  <= bus.ram_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural RAM answers the port, expected responses are
// queued at grant time from a reference memory and compared when rvalid pulses.
module tb_dmem_arbiter;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic        err;
        logic        chkData;
        logic [31:0] data;
    } respT;

    logic clk    = 1'b0;
    logic resetn = 1'b1;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    respT        ifQ[$];
    respT        memQ[$];
    logic [31:0] refMem [256];
    logic [31:0] ramArr [256];
    int          compared   = 0;
    int          mismatched = 0;
    int          cycleCnt   = 0;
    int          ramLatency = 1;
    bit          ramAuto    = 1'b1;
    int          ramCnt     = 0;
    logic        modelReady = 1'b0;
    logic        forceReady = 1'b0;
    logic [7:0]  ramIdx;

    assign bus.ram_ready = modelReady | forceReady;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic memIllegal(input logic [1:0] lane, input logic [3:0] be);
        case (be)
            4'b1111, 4'b0011, 4'b0001: return lane != 2'd0;
            4'b1100, 4'b0100:          return lane != 2'd2;
            4'b0010:                   return lane != 2'd1;
            4'b1000:                   return lane != 2'd3;
            default:                   return 1'b1;
        endcase
    endfunction

    always @(posedge clk) cycleCnt++;

    // Behavioural RAM: ready pulses ramLatency cycles after ram_req is first seen.
    always @(posedge clk) begin
        #1;
        if (resetn || !ramAuto) begin
            modelReady = 1'b0;
            ramCnt     = 0;
        end else if (modelReady) begin
            modelReady = 1'b0;
            ramCnt     = 0;
        end else if (bus.ram_req) begin
            ramCnt++;
            if (ramCnt > ramLatency) begin
                ramIdx        = bus.ram_addr[9:2];
                bus.ram_rdata = ramArr[ramIdx];
                if (bus.ram_we) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.ram_be[b]) ramArr[ramIdx][b*8 +: 8] = bus.ram_wdata[b*8 +: 8];
                end
                modelReady = 1'b1;
            end
        end
    end

    // Scoreboard: pop and compare on rvalid, push the expectation on every grant.
    always @(negedge clk) begin
        respT e;
        if (!resetn) begin
            if (bus.if_rvalid) begin
                if (ifQ.size() == 0) checkOutput("ifSpurious", 1, 0);
                else begin
                    e = ifQ.pop_front();
                    checkOutput("ifErr", bus.if_err, e.err);
                    if (e.chkData) checkOutput("ifData", bus.if_rdata, e.data);
                end
            end
            if (bus.mem_rvalid) begin
                if (memQ.size() == 0) checkOutput("memSpurious", 1, 0);
                else begin
                    e = memQ.pop_front();
                    checkOutput("memErr", bus.mem_err, e.err);
                    if (e.chkData) checkOutput("memData", bus.mem_rdata, e.data);
                end
            end
            if (bus.if_gnt) begin
                e.err     = (bus.if_addr[1:0] != 2'b00);
                e.chkData = 1'b1;
                e.data    = e.err ? 32'h0 : refMem[bus.if_addr[9:2]];
                ifQ.push_back(e);
            end
            if (bus.mem_gnt) begin
                e.err     = memIllegal(bus.mem_addr[1:0], bus.mem_be);
                e.chkData = e.err || !bus.mem_we;
                e.data    = e.err ? 32'h0 : refMem[bus.mem_addr[9:2]];
                if (!e.err && bus.mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.mem_be[b]) refMem[bus.mem_addr[9:2]][b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
                end
                memQ.push_back(e);
            end
        end
    end

    task automatic applyStimulus(input bit isMem, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be, output int gntCycle);
        int budget = 0;
        if (isMem) begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = we;
            bus.mem_addr  = addr;
            bus.mem_wdata = wdata;
            bus.mem_be    = be;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end
        gntCycle = -1;
        while (gntCycle < 0 && budget < 200) begin
            @(negedge clk);
            if (isMem ? bus.mem_gnt : bus.if_gnt) gntCycle = cycleCnt;
            else begin
                @(posedge clk);
                #1;
            end
            budget++;
        end
        if (gntCycle < 0) checkOutput(isMem ? "memGntTimeout" : "ifGntTimeout", 0, 1);
        @(posedge clk);
        #1;
        if (isMem) bus.mem_req = 1'b0;
        else       bus.if_req  = 1'b0;
    endtask

    task automatic waitResponse(input bit isMem, output int rspCycle);
        rspCycle = -1;
        for (int i = 0; i < 200 && rspCycle < 0; i++) begin
            @(negedge clk);
            if (isMem ? bus.mem_rvalid : bus.if_rvalid) rspCycle = cycleCnt;
        end
        if (rspCycle < 0) checkOutput("rspTimeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (ifQ.size() != 0 || memQ.size() != 0); i++) @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    bit          starvePat [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic [3:0]  beTab [9]      = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h5, 4'h0};

    initial begin
        int   g, gi, gm, r, c0, w;
        bit   got, sawMem, doIf, doMem, anyValid;
        logic [31:0] aI, aM, dM;
        logic [3:0]  bM;
        logic        weM;

        for (int i = 0; i < 256; i++) begin
            ramArr[i] = 32'h1000_0000 + i * 32'h0001_0203;
            refMem[i] = 32'h1000_0000 + i * 32'h0001_0203;
        end
        ramArr[64] = 32'hDEADBEEF;
        refMem[64] = 32'hDEADBEEF;

        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h0;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_be    = 4'hF;
        bus.ram_rdata = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstCtl", {bus.if_gnt, bus.if_rvalid, bus.if_err, bus.if_stall, bus.mem_gnt,
                    bus.mem_rvalid, bus.mem_err, bus.mem_stall, bus.ram_req, bus.ram_we, bus.ram_be}, 0);
        checkOutput("rstRdata", {bus.if_rdata, bus.mem_rdata}, 0);
        checkOutput("rstRam", {bus.ram_addr, bus.ram_wdata}, 0);
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;

        // IF-only read with a two-cycle RAM.
        ramLatency = 2;
        c0 = cycleCnt;
        applyStimulus(0, 1'b0, 32'h100, 32'h0, 4'h0, g);
        checkOutput("ifGntSameCycle", g, c0);
        @(negedge clk);
        checkOutput("ifRamReq", bus.ram_req, 1);
        checkOutput("ifRamAddr", bus.ram_addr, 32'h100);
        checkOutput("ifRamBe", bus.ram_be, 4'hF);
        checkOutput("ifRamWe", bus.ram_we, 0);
        waitResponse(0, r);
        checkOutput("ifLatency", r - g, 4);
        checkOutput("ifRdata", bus.if_rdata, 32'hDEADBEEF);
        @(posedge clk);
        #1;

        // Contention: MEM store wins, IF is granted in the MEM response cycle.
        ramLatency = 1;
        fork
            applyStimulus(1, 1'b1, 32'h8, 32'h12345678, 4'hF, gm);
            applyStimulus(0, 1'b0, 32'h40, 32'h0, 4'h0, gi);
            begin
                @(negedge clk);
                checkOutput("contMemGnt", bus.mem_gnt, 1);
                checkOutput("contIfGnt", bus.if_gnt, 0);
                checkOutput("contIfStall", bus.if_stall, 1);
                @(negedge clk);
                checkOutput("contRamWe", bus.ram_we, 1);
                checkOutput("contRamWdata", bus.ram_wdata, 32'h12345678);
            end
        join
        checkOutput("contIfAfterMem", gi - gm, 3);
        drain();
        applyStimulus(1, 1'b0, 32'h8, 32'h0, 4'hF, g);
        drain();

        // Starvation: both held high, MEM x4 then IF, repeating.
        ramLatency  = 0;
        bus.if_addr = 32'h20;
        bus.mem_we  = 1'b0;
        bus.mem_addr = 32'h10;
        bus.mem_be  = 4'hF;
        bus.if_req  = 1'b1;
        bus.mem_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            got = 1'b0;
            w   = 0;
            sawMem = 1'b0;
            while (!got && w < 50) begin
                @(negedge clk);
                if (bus.mem_gnt || bus.if_gnt) begin
                    got    = 1'b1;
                    sawMem = bus.mem_gnt;
                end
                w++;
                @(posedge clk);
                #1;
            end
            if (!got) checkOutput("starveTimeout", 0, 1);
            else      checkOutput($sformatf("starveGrant%0d", k), sawMem, starvePat[k]);
        end
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        drain();

        // Misaligned requests answer immediately with err and no RAM access.
        applyStimulus(1, 1'b0, 32'h3, 32'h0, 4'b0011, g);
        @(negedge clk);
        checkOutput("misMemRamReq", bus.ram_req, 0);
        checkOutput("misMemRvalid", bus.mem_rvalid, 1);
        checkOutput("misMemErr", bus.mem_err, 1);
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 32'h102, 32'h0, 4'h0, g);
        @(negedge clk);
        checkOutput("misIfRamReq", bus.ram_req, 0);
        checkOutput("misIfRvalid", bus.if_rvalid, 1);
        checkOutput("misIfErr", bus.if_err, 1);
        checkOutput("misIfRdata", bus.if_rdata, 0);
        @(posedge clk);
        #1;

        // Single-byte store, read back as a word.
        applyStimulus(1, 1'b1, 32'h6, 32'h00AB0000, 4'b0100, g);
        @(negedge clk);
        checkOutput("byteRamBe", bus.ram_be, 4'b0100);
        checkOutput("byteRamAddr", bus.ram_addr, 32'h6);
        waitResponse(1, r);
        checkOutput("byteErr", bus.mem_err, 0);
        @(posedge clk);
        #1;
        applyStimulus(1, 1'b0, 32'h4, 32'h0, 4'hF, g);
        drain();

        // Mixed random traffic, sometimes both requesters at once.
        for (int n = 0; n < 30; n++) begin
            ramLatency = $urandom_range(0, 3);
            doIf  = $urandom_range(0, 1);
            doMem = !doIf || ($urandom_range(0, 1) == 1);
            aI    = {22'h0, 8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
            aM    = {22'h0, 10'($urandom_range(0, 1023))};
            bM    = beTab[$urandom_range(0, 8)];
            weM   = 1'($urandom_range(0, 1));
            dM    = $urandom;
            fork
                begin if (doIf)  applyStimulus(0, 1'b0, aI, 32'h0, 4'h0, gi); end
                begin if (doMem) applyStimulus(1, weM, aM, dM, bM, gm); end
            join
        end
        drain();

        // Reset in the middle of an access drops it; a late ram_ready is ignored.
        ramAuto = 1'b0;
        applyStimulus(0, 1'b0, 32'h40, 32'h0, 4'h0, g);
        @(negedge clk);
        checkOutput("rstMidRamReq", bus.ram_req, 1);
        resetn = 1'b1;
        #1;
        checkOutput("rstMidCtl", {bus.if_gnt, bus.if_rvalid, bus.if_err, bus.if_stall, bus.mem_gnt,
                    bus.mem_rvalid, bus.mem_err, bus.mem_stall, bus.ram_req, bus.ram_we, bus.ram_be}, 0);
        checkOutput("rstMidRam", {bus.ram_addr, bus.ram_wdata}, 0);
        ifQ.delete();
        memQ.delete();
        @(posedge clk);
        #1;
        resetn     = 1'b0;
        forceReady = 1'b1;
        @(posedge clk);
        #1;
        forceReady = 1'b0;
        anyValid   = 1'b0;
        repeat (4) begin
            @(negedge clk);
            anyValid = anyValid | bus.if_rvalid | bus.mem_rvalid;
        end
        checkOutput("rstNoRvalid", anyValid, 0);
        @(posedge clk);
        #1;
        ramAuto = 1'b1;
        applyStimulus(0, 1'b0, 32'h100, 32'h0, 4'h0, g);
        drain();

        checkOutput("ifQEmpty", ifQ.size(), 0);
        checkOutput("memQEmpty", memQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
